// File: rtl/instr_encode_if.sv
// Purpose : handshake/bus bundle for instr_encode.
//   Request side : in_valid, in_ready, in_op, in_rs1, in_rs2, in_rd, in_imm
//   Response side: out_valid, out_ready, out_instr, out_err
//   Status       : enc_count (words popped without error)
// Modports: master = producer/consumer (testbench, loader), slave = encoder.
interface instr_encode_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_op;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [4:0]       in_rd;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count
    );
endinterface

// File: rtl/instr_encode.sv
// Purpose : RV32I instruction encoder. Packs an internal op code plus register and
//           immediate fields into a 32-bit RV32I word, buffered in a 2-entry output
//           FIFO (1-cycle latency when empty).
// Ports   : clk, rst_n (async, active low); bus (instr_encode_if.slave) carrying the
//           in_* request handshake, out_* response handshake and enc_count.
// Config  : IMM_CHECK_EN - when defined, immediates that do not fit their format
//           produce out_err=1 / out_instr=0; otherwise they are truncated.
module instr_encode #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    instr_encode_if.slave bus
);

`ifdef IMM_CHECK_EN
    localparam bit IMM_CHK = 1'b1;
`else
    localparam bit IMM_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD} fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } word_t;

    fmt_e        fmt;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        fits12, fits13, fits21, imm_bad;
    word_t       enc_w;

    word_t            head_q, head_d, tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic             push, pop;

    assign imm = bus.in_imm;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign rd  = bus.in_rd;

    // Sign-extension checks: upper bits all equal means the value fits the field.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Op decode: format, major opcode, funct3, funct7.
    always_comb begin
        fmt = F_BAD; opc = 7'h00; f3 = 3'd0; f7 = 7'h00;
        case (bus.in_op)
            6'h00: begin fmt = F_U;  opc = 7'h37; end
            6'h01: begin fmt = F_U;  opc = 7'h17; end
            6'h02: begin fmt = F_J;  opc = 7'h6F; end
            6'h03: begin fmt = F_I;  opc = 7'h67; f3 = 3'd0; end
            6'h04: begin fmt = F_B;  opc = 7'h63; f3 = 3'd0; end
            6'h05: begin fmt = F_B;  opc = 7'h63; f3 = 3'd1; end
            6'h06: begin fmt = F_B;  opc = 7'h63; f3 = 3'd4; end
            6'h07: begin fmt = F_B;  opc = 7'h63; f3 = 3'd5; end
            6'h08: begin fmt = F_B;  opc = 7'h63; f3 = 3'd6; end
            6'h09: begin fmt = F_B;  opc = 7'h63; f3 = 3'd7; end
            6'h0A: begin fmt = F_I;  opc = 7'h03; f3 = 3'd0; end
            6'h0B: begin fmt = F_I;  opc = 7'h03; f3 = 3'd1; end
            6'h0C: begin fmt = F_I;  opc = 7'h03; f3 = 3'd2; end
            6'h0D: begin fmt = F_I;  opc = 7'h03; f3 = 3'd4; end
            6'h0E: begin fmt = F_I;  opc = 7'h03; f3 = 3'd5; end
            6'h0F: begin fmt = F_S;  opc = 7'h23; f3 = 3'd0; end
            6'h10: begin fmt = F_S;  opc = 7'h23; f3 = 3'd1; end
            6'h11: begin fmt = F_S;  opc = 7'h23; f3 = 3'd2; end
            6'h12: begin fmt = F_I;  opc = 7'h13; f3 = 3'd0; end
            6'h13: begin fmt = F_I;  opc = 7'h13; f3 = 3'd2; end
            6'h14: begin fmt = F_I;  opc = 7'h13; f3 = 3'd3; end
            6'h15: begin fmt = F_I;  opc = 7'h13; f3 = 3'd4; end
            6'h16: begin fmt = F_I;  opc = 7'h13; f3 = 3'd6; end
            6'h17: begin fmt = F_I;  opc = 7'h13; f3 = 3'd7; end
            6'h18: begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
            6'h19: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
            6'h1A: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            6'h1B: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; end
            6'h1C: begin fmt = F_R;  opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            6'h1D: begin fmt = F_R;  opc = 7'h33; f3 = 3'd1; end
            6'h1E: begin fmt = F_R;  opc = 7'h33; f3 = 3'd2; end
            6'h1F: begin fmt = F_R;  opc = 7'h33; f3 = 3'd3; end
            6'h20: begin fmt = F_R;  opc = 7'h33; f3 = 3'd4; end
            6'h21: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; end
            6'h22: begin fmt = F_R;  opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            6'h23: begin fmt = F_R;  opc = 7'h33; f3 = 3'd6; end
            6'h24: begin fmt = F_R;  opc = 7'h33; f3 = 3'd7; end
            default: fmt = F_BAD;
        endcase
    end

    // Field packing per format.
    always_comb begin
        enc_w   = '0;
        imm_bad = 1'b0;
        case (fmt)
            F_R:  enc_w.instr = {f7, rs2, rs1, f3, rd, opc};
            F_I:  begin enc_w.instr = {imm[11:0], rs1, f3, rd, opc}; imm_bad = ~fits12; end
            F_SH: begin enc_w.instr = {f7, imm[4:0], rs1, f3, rd, opc}; imm_bad = |imm[31:5]; end
            F_S:  begin enc_w.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}; imm_bad = ~fits12; end
            F_B:  begin
                enc_w.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                imm_bad = ~fits13 | imm[0];
            end
            F_U:  begin enc_w.instr = {imm[31:12], rd, opc}; imm_bad = |imm[11:0]; end
            F_J:  begin
                enc_w.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                imm_bad = ~fits21 | imm[0];
            end
            default: enc_w.err = 1'b1;
        endcase
        if (IMM_CHK && imm_bad) begin
            enc_w.instr = '0;
            enc_w.err   = 1'b1;
        end
    end

    // 2-entry FIFO: head_q drives out_*, tail_q holds the second word.
    // head_q is left untouched when the FIFO drains so out_* hold their last value.
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        enc_cnt_d = enc_cnt_q;
        cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) head_d = enc_w;
        else if (pop && cnt_q == 2'd2)                          head_d = tail_q;
        if (push && cnt_q == 2'd1 && !pop) tail_d = enc_w;
        if (pop && !head_q.err) enc_cnt_d = enc_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            enc_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            enc_cnt_q <= enc_cnt_d;
        end
    end

    // Gating with rst_n drops in_ready in the same cycle reset asserts.
    assign bus.in_ready  = rst_n & (cnt_q != 2'd2);
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_instr = head_q.instr;
    assign bus.out_err   = head_q.err;
    assign bus.enc_count = enc_cnt_q;

endmodule
